// File: rtl/msrv32_lsu_ctrl.sv
// rtl/msrv32_lsu_ctrl.sv - load/store unit bus controller with timeout abort
// Optional feature macro: MSRV32_MISALIGN_TRAP_EN (trap misaligned half/word
// accesses instead of issuing them with the low address bits ignored).
module msrv32_lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        start_in,
  input  logic        is_store_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_wmask_out,
  input  logic        dmem_gnt_in,
  input  logic        dmem_rvalid_in,
  input  logic [31:0] dmem_rdata_in,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        bus_error_out,
  output logic        misaligned_out
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_t;

  // Last counter value before abort: REQ+RSP may last TIMEOUT_CYCLES cycles.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        bus_error_q, bus_error_d;
  logic        misaligned_q, misaligned_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;

  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic [31:0] ld_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        misalign;
  logic        timeout;

  // Store lane replication and byte strobes from the incoming operands.
  always_comb begin
    st_wdata = store_data_in;
    st_wmask = 4'b1111;
    case (load_size_in)
      2'b00: begin
        st_wdata = {4{store_data_in[7:0]}};
        st_wmask = 4'b0001 << addr_in[1:0];
      end
      2'b01: begin
        st_wdata = {2{store_data_in[15:0]}};
        st_wmask = 4'b0011 << {addr_in[1], 1'b0};
      end
      default: begin
        st_wdata = store_data_in;
        st_wmask = 4'b1111;
      end
    endcase
  end

`ifdef MSRV32_MISALIGN_TRAP_EN
  assign misalign = ((load_size_in == 2'b01) && addr_in[0]) ||
                    (load_size_in[1] && (addr_in[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Load lane selection and extension using the operands latched at start.
  always_comb begin
    ld_byte = dmem_rdata_in[7:0];
    case (lane_q)
      2'b00: ld_byte = dmem_rdata_in[7:0];
      2'b01: ld_byte = dmem_rdata_in[15:8];
      2'b10: ld_byte = dmem_rdata_in[23:16];
      default: ld_byte = dmem_rdata_in[31:24];
    endcase
    ld_half = lane_q[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
    case (size_q)
      2'b00: ld_ext = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01: ld_ext = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = dmem_rdata_in;
    endcase
  end

  assign timeout = (cnt_q == TO_LAST);

  // Next-state, next-output and combinational stall.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    bus_error_d  = 1'b0;
    misaligned_d = 1'b0;
    cnt_d        = cnt_q;
    lane_d       = lane_q;
    size_d       = size_q;
    uns_d        = uns_q;
    stall_out    = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_out = start_in;
        cnt_d     = 8'd0;
        if (start_in) begin
          we_d    = is_store_in;
          addr_d  = {addr_in[31:2], 2'b00};
          wdata_d = st_wdata;
          wmask_d = st_wmask;
          lane_d  = addr_in[1:0];
          size_d  = load_size_in;
          uns_d   = load_unsigned_in;
          if (misalign) begin
            misaligned_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            req_d   = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall_out = 1'b1;
        cnt_d     = cnt_q + 8'd1;
        if (dmem_gnt_in) begin
          req_d   = 1'b0;
          state_d = we_q ? S_DONE : S_RSP;
        end else if (timeout) begin
          req_d       = 1'b0;
          bus_error_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_RSP: begin
        stall_out = 1'b1;
        cnt_d     = cnt_q + 8'd1;
        if (dmem_rvalid_in) begin
          load_data_d  = ld_ext;
          load_valid_d = 1'b1;
          state_d      = S_DONE;
        end else if (timeout) begin
          bus_error_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wmask_q      <= 4'd0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      bus_error_q  <= 1'b0;
      misaligned_q <= 1'b0;
      cnt_q        <= 8'd0;
      lane_q       <= 2'd0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_error_q  <= bus_error_d;
      misaligned_q <= misaligned_d;
      cnt_q        <= cnt_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
    end
  end

  assign dmem_req_out   = req_q;
  assign dmem_we_out    = we_q;
  assign dmem_addr_out  = addr_q;
  assign dmem_wdata_out = wdata_q;
  assign dmem_wmask_out = wmask_q;
  assign load_data_out  = load_data_q;
  assign load_valid_out = load_valid_q;
  assign bus_error_out  = bus_error_q;
  assign misaligned_out = misaligned_q;

endmodule

// File: tb/tb_msrv32_lsu_ctrl.sv
// tb/tb_msrv32_lsu_ctrl.sv - randomized self-checking bench for msrv32_lsu_ctrl
module tb_msrv32_lsu_ctrl;

  localparam int TO = 255;

  logic        clk_in = 1'b0;
  logic        reset_n_in = 1'b0;
  logic        start_in = 1'b0;
  logic        is_store_in = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] store_data_in = '0;
  logic [1:0]  load_size_in = '0;
  logic        load_unsigned_in = 1'b0;
  logic        dmem_req_out, dmem_we_out;
  logic [31:0] dmem_addr_out, dmem_wdata_out;
  logic [3:0]  dmem_wmask_out;
  logic        dmem_gnt_in = 1'b0;
  logic        dmem_rvalid_in = 1'b0;
  logic [31:0] dmem_rdata_in = '0;
  logic        stall_out;
  logic [31:0] load_data_out;
  logic        load_valid_out, bus_error_out, misaligned_out;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] last_load = '0;

  msrv32_lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .start_in(start_in),
    .is_store_in(is_store_in), .addr_in(addr_in), .store_data_in(store_data_in),
    .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
    .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
    .dmem_addr_out(dmem_addr_out), .dmem_wdata_out(dmem_wdata_out),
    .dmem_wmask_out(dmem_wmask_out), .dmem_gnt_in(dmem_gnt_in),
    .dmem_rvalid_in(dmem_rvalid_in), .dmem_rdata_in(dmem_rdata_in),
    .stall_out(stall_out), .load_data_out(load_data_out),
    .load_valid_out(load_valid_out), .bus_error_out(bus_error_out),
    .misaligned_out(misaligned_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req"}, 32'(dmem_req_out), 0);
    check_eq({tag, "_we"}, 32'(dmem_we_out), 0);
    check_eq({tag, "_addr"}, dmem_addr_out, 0);
    check_eq({tag, "_wdata"}, dmem_wdata_out, 0);
    check_eq({tag, "_wmask"}, 32'(dmem_wmask_out), 0);
    check_eq({tag, "_ldata"}, load_data_out, 0);
    check_eq({tag, "_lvalid"}, 32'(load_valid_out), 0);
    check_eq({tag, "_berr"}, 32'(bus_error_out), 0);
    check_eq({tag, "_mis"}, 32'(misaligned_out), 0);
  endtask

  // One access: g = REQ cycles before grant (-1 never), r = RSP cycles before rvalid (-1 never).
  task automatic run_txn(input bit st, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input bit uns, input int g, input int r,
                         input logic [31:0] rd);
    logic [31:0] e_addr, e_wdata, e_ldata, lane;
    logic [3:0]  e_wmask;
    bit          mis, err;
    int          nreq, nrsp;
    e_addr = a & 32'hFFFF_FFFC;
    if (sz == 2'b00) begin
      e_wdata = (d & 32'hFF) * 32'h0101_0101;
      e_wmask = 4'(1 << a[1:0]);
      lane = (rd >> (8 * a[1:0])) & 32'hFF;
      e_ldata = (!uns && lane[7]) ? (lane | 32'hFFFF_FF00) : lane;
    end else if (sz == 2'b01) begin
      e_wdata = (d & 32'hFFFF) * 32'h0001_0001;
      e_wmask = 4'(3 << (2 * a[1]));
      lane = (rd >> (16 * a[1])) & 32'hFFFF;
      e_ldata = (!uns && lane[15]) ? (lane | 32'hFFFF_0000) : lane;
    end else begin
      e_wdata = d;
      e_wmask = 4'hF;
      e_ldata = rd;
    end
`ifdef MSRV32_MISALIGN_TRAP_EN
    mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    nreq = (g < 0 || g + 1 > TO) ? TO : g + 1;
    err  = (nreq == TO) && (g < 0 || g + 1 > TO);
    nrsp = 0;
    if (!st && !err) begin
      if (r < 0 || nreq + r + 1 > TO) begin
        nrsp = TO - nreq;
        err  = 1'b1;
      end else begin
        nrsp = r + 1;
      end
    end

    @(posedge clk_in); #1;
    start_in = 1'b1; is_store_in = st; addr_in = a; store_data_in = d;
    load_size_in = sz; load_unsigned_in = uns; dmem_rdata_in = rd;
    dmem_gnt_in = 1'($urandom_range(1)); dmem_rvalid_in = 1'($urandom_range(1));
    @(negedge clk_in);
    check_eq("idle_stall", 32'(stall_out), 1);
    check_eq("idle_req", 32'(dmem_req_out), 0);

    if (!mis) begin
      for (int i = 0; i < nreq; i++) begin
        @(posedge clk_in); #1;
        dmem_gnt_in = (i == g);
        dmem_rvalid_in = 1'($urandom_range(1));
        @(negedge clk_in);
        check_eq("req_req", 32'(dmem_req_out), 1);
        check_eq("req_stall", 32'(stall_out), 1);
        check_eq("req_addr", dmem_addr_out, e_addr);
        check_eq("req_we", 32'(dmem_we_out), 32'(st));
        if (st) begin
          check_eq("req_wdata", dmem_wdata_out, e_wdata);
          check_eq("req_wmask", 32'(dmem_wmask_out), 32'(e_wmask));
        end
      end
      for (int j = 0; j < nrsp; j++) begin
        @(posedge clk_in); #1;
        dmem_gnt_in = 1'b0;
        dmem_rvalid_in = (j == r);
        @(negedge clk_in);
        check_eq("rsp_req", 32'(dmem_req_out), 0);
        check_eq("rsp_stall", 32'(stall_out), 1);
      end
    end

    @(posedge clk_in); #1;
    dmem_gnt_in = 1'($urandom_range(1)); dmem_rvalid_in = 1'($urandom_range(1));
    if (!st && !err && !mis) last_load = e_ldata;
    @(negedge clk_in);
    check_eq("done_stall", 32'(stall_out), 0);
    check_eq("done_req", 32'(dmem_req_out), 0);
    check_eq("done_lvalid", 32'(load_valid_out), 32'(!st && !err && !mis));
    check_eq("done_berr", 32'(bus_error_out), 32'(err && !mis));
    check_eq("done_mis", 32'(misaligned_out), 32'(mis));
    check_eq("done_ldata", load_data_out, last_load);

    @(posedge clk_in); #1;
    start_in = 1'b0; dmem_gnt_in = 1'b0; dmem_rvalid_in = 1'($urandom_range(1));
    @(negedge clk_in);
    check_eq("post_stall", 32'(stall_out), 0);
    check_eq("post_req", 32'(dmem_req_out), 0);
    check_eq("post_lvalid", 32'(load_valid_out), 0);
    check_eq("post_berr", 32'(bus_error_out), 0);
    check_eq("post_ldata", load_data_out, last_load);
  endtask

  initial begin
    #2;
    check_all_zero("rst");
    check_eq("rst_stall", 32'(stall_out), 0);
    repeat (2) @(posedge clk_in);
    #1 reset_n_in = 1'b1;

    run_txn(1'b1, 32'h0000_1003, 32'h0000_00AB, 2'b00, 1'b0, 2, 0, 32'h0);
    run_txn(1'b0, 32'h0000_2001, 32'h0, 2'b00, 1'b0, 1, 2, 32'h0000_8000);
    run_txn(1'b0, 32'h0000_2001, 32'h0, 2'b00, 1'b1, 0, 0, 32'h0000_8000);
    run_txn(1'b0, 32'h0000_2002, 32'h0, 2'b01, 1'b0, 3, 1, 32'h1234_5678);
    run_txn(1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 2'b10, 1'b0, -1, 0, 32'h0);
    run_txn(1'b1, 32'h0000_4004, 32'hCAFE_F00D, 2'b01, 1'b0, TO - 1, 0, 32'h0);
    run_txn(1'b0, 32'h0000_4008, 32'h0, 2'b11, 1'b0, 10, TO - 12, 32'h8765_4321);
    run_txn(1'b0, 32'h0000_400C, 32'h0, 2'b10, 1'b0, 5, -1, 32'h1111_2222);
    run_txn(1'b0, 32'h0000_3001, 32'h0, 2'b10, 1'b0, 0, 0, 32'hA5A5_5A5A);

    for (int k = 0; k < 40; k++) begin
      run_txn(1'($urandom_range(1)), $urandom, $urandom, 2'($urandom_range(3)),
              1'($urandom_range(1)), int'($urandom_range(5)), int'($urandom_range(5)), $urandom);
    end

    // Reset while waiting for read data; late rvalid must be ignored.
    @(posedge clk_in); #1;
    start_in = 1'b1; is_store_in = 1'b0; addr_in = 32'h0000_5000; load_size_in = 2'b10;
    dmem_gnt_in = 1'b0; dmem_rvalid_in = 1'b0; dmem_rdata_in = 32'h7777_7777;
    @(posedge clk_in); #1;
    dmem_gnt_in = 1'b1;
    @(posedge clk_in); #1;
    dmem_gnt_in = 1'b0;
    @(negedge clk_in);
    check_eq("pre_rst_stall", 32'(stall_out), 1);
    #2;
    start_in = 1'b0; reset_n_in = 1'b0;
    #1;
    check_all_zero("midrst");
    check_eq("midrst_stall", 32'(stall_out), 0);
    @(posedge clk_in); #1;
    reset_n_in = 1'b1; dmem_rvalid_in = 1'b1; dmem_gnt_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      check_eq("late_lvalid", 32'(load_valid_out), 0);
      check_eq("late_req", 32'(dmem_req_out), 0);
      check_eq("late_ldata", load_data_out, 0);
      check_eq("late_stall", 32'(stall_out), 0);
    end
    dmem_rvalid_in = 1'b0; dmem_gnt_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
